// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based decode stall controller.
// Each architectural register carries a small countdown holding the number of
// cycles before its pending long-latency result becomes bypassable. Decode is
// held while a source or destination register is still counting. EX
// multi-cycle requests are merged into the same stall vector.
module pipe_hazard_ctrl #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LAT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_reg1_read,
  input  logic [AW-1:0]    id_reg1_addr,
  input  logic             id_reg2_read,
  input  logic [AW-1:0]    id_reg2_addr,
  input  logic             id_wreg,
  input  logic [AW-1:0]    id_wd,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             stallreq_ex,
  output logic [5:0]       stall,
  output logic [NREG-1:0]  busy_regs,
  output logic [CNT_W-1:0] stall_cycles
);

  // Per-register remaining latency; entry 0 is kept at zero.
  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             id_haz;
  logic             issue;
  logic [5:0]       stall_vec;
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;

  // Hazard detection against the current scoreboard contents.
  always_comb begin
    raw1   = id_valid && id_reg1_read && (id_reg1_addr != '0) &&
             (cnt_q[id_reg1_addr] != '0);
    raw2   = id_valid && id_reg2_read && (id_reg2_addr != '0) &&
             (cnt_q[id_reg2_addr] != '0);
    waw    = id_valid && id_wreg && (id_wd != '0) && (cnt_q[id_wd] != '0);
    id_haz = raw1 || raw2 || waw;
  end

  // Stall vector: an EX busy request outranks a decode hazard.
  always_comb begin
    stall_vec = 6'b000000;
    if (stallreq_ex) begin
      stall_vec = 6'b001111;
    end else if (id_haz) begin
      stall_vec = 6'b000111;
    end
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    stall = rst ? 6'b000000 : stall_vec;
  end

  // A long-latency writer leaves decode only when nothing holds it back.
  always_comb begin
    issue = id_valid && !id_haz && !stallreq_ex && id_wreg &&
            (id_wd != '0) && (id_lat != '0);
  end

  // Scoreboard next state: issue loads, otherwise count down unless EX is frozen.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue && (id_wd == AW'(r))) begin
        cnt_d[r] = id_lat;
      end else if (!stallreq_ex && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_vec[0] && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // Performance counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // Busy view of each scoreboard entry, blanked during reset.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign busy_regs[gi] = !rst && (cnt_q[gi] != '0);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_reg1_read;
  logic [4:0]  id_reg1_addr;
  logic        id_reg2_read;
  logic [4:0]  id_reg2_addr;
  logic        id_wreg;
  logic [4:0]  id_wd;
  logic [2:0]  id_lat;
  logic        stallreq_ex;
  logic [5:0]  stall;
  logic [31:0] busy_regs;
  logic [15:0] stall_cycles;

  int n_vec;
  int n_bad;

  pipe_hazard_ctrl #(
    .NREG (32),
    .AW   (5),
    .LAT_W(3),
    .CNT_W(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_reg1_read(id_reg1_read),
    .id_reg1_addr(id_reg1_addr),
    .id_reg2_read(id_reg2_read),
    .id_reg2_addr(id_reg2_addr),
    .id_wreg     (id_wreg),
    .id_wd       (id_wd),
    .id_lat      (id_lat),
    .stallreq_ex (stallreq_ex),
    .stall       (stall),
    .busy_regs   (busy_regs),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation and log the transaction.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Apply one decode-stage vector for the current cycle.
  task automatic drive(input logic v, input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2, input logic w,
                       input logic [4:0] wd, input logic [2:0] lat, input logic ex);
    id_valid     = v;
    id_reg1_read = r1;
    id_reg1_addr = a1;
    id_reg2_read = r2;
    id_reg2_addr = a2;
    id_wreg      = w;
    id_wd        = wd;
    id_lat       = lat;
    stallreq_ex  = ex;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  // Move to the middle of the next cycle region (inputs change just after the edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Sample combinational outputs well before the next active edge.
  task automatic settle();
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1);
    next_cycle();
    next_cycle();
    settle();
    chk("rst_stall_gated", {26'd0, stall}, 32'h0);
    chk("rst_busy", busy_regs, 32'h0);
    chk("rst_cycles", {16'd0, stall_cycles}, 32'h0);
    rst = 1'b0;
    idle();
    next_cycle();

    // 1: issue r5 lat 3, dependent read stalls three cycles
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 3'd3, 1'b0);
    settle();
    chk("t1_issue_stall", {26'd0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t1_c1_stall", {26'd0, stall}, 32'h07);
    chk("t1_c1_busy", busy_regs, 32'h20);
    next_cycle();
    settle();
    chk("t1_c2_stall", {26'd0, stall}, 32'h07);
    next_cycle();
    settle();
    chk("t1_c3_stall", {26'd0, stall}, 32'h07);
    next_cycle();
    settle();
    chk("t1_c4_stall", {26'd0, stall}, 32'h0);
    chk("t1_c4_busy", busy_regs, 32'h0);
    chk("t1_cycles", {16'd0, stall_cycles}, 32'd3);
    idle();
    next_cycle();

    // 2: same but EX busy in t+2 freezes the countdown one cycle
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 3'd3, 1'b0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t2_c1_stall", {26'd0, stall}, 32'h07);
    next_cycle();
    stallreq_ex = 1'b1;
    settle();
    chk("t2_c2_exstall", {26'd0, stall}, 32'h0F);
    next_cycle();
    stallreq_ex = 1'b0;
    settle();
    chk("t2_c3_stall", {26'd0, stall}, 32'h07);
    chk("t2_c3_busy", busy_regs, 32'h20);
    next_cycle();
    settle();
    chk("t2_c4_stall", {26'd0, stall}, 32'h07);
    next_cycle();
    settle();
    chk("t2_c5_stall", {26'd0, stall}, 32'h0);
    chk("t2_cycles", {16'd0, stall_cycles}, 32'd7);
    idle();
    next_cycle();

    // 3: register 0 is never tracked
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 3'd7, 1'b0);
    settle();
    chk("t3_issue_stall", {26'd0, stall}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t3_read_stall", {26'd0, stall}, 32'h0);
    chk("t3_busy", busy_regs, 32'h0);
    next_cycle();
    idle();
    settle();
    chk("t3_busy_after", busy_regs, 32'h0);
    next_cycle();

    // 4: WAW on r7 (cnt 2) stalls two cycles, then lat-4 issue
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 3'd2, 1'b0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 3'd4, 1'b0);
    settle();
    chk("t4_waw1_stall", {26'd0, stall}, 32'h07);
    chk("t4_waw1_busy", busy_regs, 32'h80);
    next_cycle();
    settle();
    chk("t4_waw2_stall", {26'd0, stall}, 32'h07);
    next_cycle();
    settle();
    chk("t4_issue_stall", {26'd0, stall}, 32'h0);
    chk("t4_issue_busy", busy_regs, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t4_b1_busy", busy_regs, 32'h80);
    chk("t4_raw2_stall", {26'd0, stall}, 32'h07);
    next_cycle();
    drive(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t4_b2_busy", busy_regs, 32'h80);
    chk("t4_other_reg", {26'd0, stall}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t4_b3_busy", busy_regs, 32'h80);
    chk("t4_invalid_nostall", {26'd0, stall}, 32'h0);
    next_cycle();
    idle();
    settle();
    chk("t4_b4_busy", busy_regs, 32'h80);
    next_cycle();
    settle();
    chk("t4_b5_busy", busy_regs, 32'h0);
    chk("t4_cycles", {16'd0, stall_cycles}, 32'd10);

    // 5: reset mid-flight clears the scoreboard
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 3'd5, 1'b0);
    next_cycle();
    idle();
    settle();
    chk("t5_busy", busy_regs, 32'h200);
    next_cycle();
    rst = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
    settle();
    chk("t5_rst_stall", {26'd0, stall}, 32'h0);
    chk("t5_rst_busy", busy_regs, 32'h0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("t5_after_stall", {26'd0, stall}, 32'h0);
    chk("t5_after_busy", busy_regs, 32'h0);
    chk("t5_after_cycles", {16'd0, stall_cycles}, 32'd0);
    next_cycle();

    // 6: long EX stall saturates the performance counter
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1);
    for (int i = 0; i < 65540; i++) begin
      if (i == 65534 || i == 65535) begin
        settle();
        chk("t6_count", {16'd0, stall_cycles}, i);
      end
      next_cycle();
    end
    settle();
    chk("t6_saturated", {16'd0, stall_cycles}, 32'hFFFF);
    chk("t6_stall", {26'd0, stall}, 32'h0F);
    next_cycle();
    idle();
    settle();
    chk("t6_hold", {16'd0, stall_cycles}, 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
